// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch requester and a
// data requester, with a single outstanding transaction and a fetch anti-starvation limit.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req_val,
    input  logic [31:0] imem_req_addr,
    output logic        imem_req_rdy,
    output logic        imem_resp_val,
    output logic [31:0] imem_resp_data,
    input  logic        dmem_req_val,
    input  logic        dmem_req_rw,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_wdata,
    output logic        dmem_req_rdy,
    output logic        dmem_resp_val,
    output logic [31:0] dmem_resp_data,
    output logic        mem_req_val,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_req_rdy,
    input  logic        mem_resp_val,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic        err_spurious,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on a cycle where val && rdy are both high;
    // val never depends on rdy, and responses are single-cycle val pulses with no back-pressure.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       in_idle;
    logic       force_i;
    logic       grant_d;
    logic       grant_i;
    logic       accept;

    // Grant paths are gated by rst so nothing leaks out while reset is held.
    assign in_idle = rst && (state == IDLE);
    assign force_i = imem_req_val && (starve_cnt == LIMIT);
    assign grant_d = in_idle && dmem_req_val && !force_i;
    assign grant_i = in_idle && imem_req_val && !grant_d;
    assign accept  = (grant_d || grant_i) && mem_req_rdy;

    always_comb begin
        mem_req_val   = grant_d || grant_i;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wdata = 32'd0;
        if (grant_d) begin
            mem_req_rw    = dmem_req_rw;
            mem_req_addr  = dmem_req_addr;
            mem_req_wdata = dmem_req_wdata;
        end else if (grant_i) begin
            mem_req_addr  = imem_req_addr;
        end
    end

    assign imem_req_rdy   = grant_i && mem_req_rdy;
    assign dmem_req_rdy   = grant_d && mem_req_rdy;
    assign imem_resp_val  = (state == WAIT_I) && mem_resp_val;
    assign dmem_resp_val  = (state == WAIT_D) && mem_resp_val;
    assign imem_resp_data = mem_resp_data;
    assign dmem_resp_data = mem_resp_data;
    assign state_dbg      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            err_spurious <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_resp_val) begin
                        err_spurious <= 1'b1;
                    end
                    if (accept) begin
                        busy <= 1'b1;
                        if (grant_d) begin
                            state <= WAIT_D;
                            if (imem_req_val && (starve_cnt < LIMIT)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            state      <= WAIT_I;
                            starve_cnt <= 4'd0;
                        end
                    end
                end
                WAIT_I, WAIT_D: begin
                    // mem_req_rdy is deliberately not looked at while waiting.
                    if (mem_resp_val) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
